// File: rtl/frame_stack_pkg.sv
// Processor constants shared by the frame stack.
// Frame geometry and the restore FSM encoding.
package frame_stack_pkg;

  localparam int REG_W = 16;
  localparam int NUM_SAVED = 15;
  localparam int FRAME_W = REG_W * NUM_SAVED;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } fsState_e;

endpackage

// File: rtl/frame_stack_mem.sv
// Frame storage: single-port RAM, synchronous write,
// registered read (read-before-write on a shared address).
module frame_stack_mem #(
  parameter int FRAME_W = frame_stack_pkg::FRAME_W,
  parameter int DEPTH = frame_stack_pkg::DEPTH,
  parameter int PTR_W = frame_stack_pkg::PTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [PTR_W-1:0]   addr,
  input  logic [FRAME_W-1:0] wData,
  output logic [FRAME_W-1:0] rData
);

  logic [FRAME_W-1:0] mem [DEPTH];

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wData;
    end
  end

  // Read register sees the old word when writing the same slot
  always_ff @(posedge clk) begin
    if (reset) begin
      rData <= '0;
    end else if (re) begin
      rData <= mem[addr];
    end
  end

endmodule

// File: rtl/frame_stack.sv
// Call-frame stack beside the register file.
// Saves frames on call, restores the top frame on return.
module frame_stack #(
  parameter int FRAME_W = frame_stack_pkg::FRAME_W,
  parameter int DEPTH = frame_stack_pkg::DEPTH,
  parameter int PTR_W = frame_stack_pkg::PTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               clear_err,
  output logic [FRAME_W-1:0] frame_out,
  output logic               restore,
  output logic [PTR_W:0]     count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
);

  import frame_stack_pkg::*;

  fsState_e state;
  fsState_e stateNext;

  logic popOk;
  logic pushOk;
  logic ovSet;
  logic unSet;
  logic [PTR_W-1:0] lowCnt;
  logic [PTR_W-1:0] addr;

  assign full = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign popOk = pop && !empty;
  assign pushOk = push && (!full || popOk);
  assign ovSet = push && full && !popOk;
  assign unSet = pop && empty;

  assign lowCnt = count[PTR_W-1:0];
  assign addr = popOk ? lowCnt - PTR_W'(1) : lowCnt;

  frame_stack_mem #(
    .FRAME_W(FRAME_W),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) uMem (
    .clk(clk),
    .reset(reset),
    .we(pushOk && !reset),
    .re(popOk),
    .addr(addr),
    .wData(frame_in),
    .rData(frame_out)
  );

  // Occupancy: a tail call leaves it unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (pushOk && !popOk) begin
      count <= count + (PTR_W+1)'(1);
    end else if (popOk && !pushOk) begin
      count <= count - (PTR_W+1)'(1);
    end
  end

  // Sticky errors; a fresh error beats clear_err
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovSet) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (unSet) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Restore FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Every accepted pop lands in RESTORE for one cycle
  always_comb begin
    stateNext = IDLE;
    restore = (state == RESTORE);
    unique case (state)
      IDLE:    stateNext = popOk ? RESTORE : IDLE;
      RESTORE: stateNext = popOk ? RESTORE : IDLE;
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_stack.sv
// Bench for frame_stack: queue model checked every cycle,
// plus literal expectations on directed vectors.
module tb_frame_stack;

  localparam int FW = 240;
  localparam int DP = 16;
  localparam int PW = 4;

  logic clk;
  logic reset;
  logic push;
  logic pop;
  logic [FW-1:0] frame_in;
  logic clear_err;
  logic [FW-1:0] frame_out;
  logic restore;
  logic [PW:0] count;
  logic full;
  logic empty;
  logic overflow;
  logic underflow;

  frame_stack dut (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .frame_in(frame_in),
    .clear_err(clear_err),
    .frame_out(frame_out),
    .restore(restore),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Model state
  logic [FW-1:0] q[$];
  logic [FW-1:0] mOut;
  logic mRst;
  logic mOv;
  logic mUn;
  logic mValid = 1'b0;

  // Literal expectations for the upcoming edge
  logic litOn;
  logic [FW-1:0] litOut;
  logic litRst;
  int litCnt;
  logic litOv;
  logic litUn;
  logic lOn = 1'b0;
  logic [FW-1:0] lOut;
  logic lRst;
  int lCnt;
  logic lOv;
  logic lUn;

  function automatic logic [FW-1:0] mk(input logic [15:0] r);
    return {15{r}};
  endfunction

  function automatic logic [FW-1:0] randFrame();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
    return t[FW-1:0];
  endfunction

  always @(posedge clk) begin
    bit okPop;
    bit eOv;
    bit eUn;
    lOn = litOn;
    lOut = litOut;
    lRst = litRst;
    lCnt = litCnt;
    lOv = litOv;
    lUn = litUn;
    if (reset) begin
      q.delete();
      mOut = '0;
      mRst = 1'b0;
      mOv = 1'b0;
      mUn = 1'b0;
      mValid = 1'b1;
    end else if (mValid) begin
      okPop = pop && (q.size() > 0);
      eOv = push && !okPop && (q.size() == DP);
      eUn = pop && (q.size() == 0);
      mRst = okPop;
      if (okPop) begin
        mOut = q[$];
        void'(q.pop_back());
      end
      if (push && q.size() < DP) q.push_back(frame_in);
      if (eOv) mOv = 1'b1;
      else if (clear_err) mOv = 1'b0;
      if (eUn) mUn = 1'b1;
      else if (clear_err) mUn = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [FW-1:0] act,
                     input logic [FW-1:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mValid) begin
      chk("frame_out", frame_out, mOut);
      chk("restore", FW'(restore), FW'(mRst));
      chk("count", FW'(count), FW'(q.size()));
      chk("full", FW'(full), FW'(q.size() == DP));
      chk("empty", FW'(empty), FW'(q.size() == 0));
      chk("overflow", FW'(overflow), FW'(mOv));
      chk("underflow", FW'(underflow), FW'(mUn));
      if (lOn) begin
        chk("lit_out", frame_out, lOut);
        chk("lit_restore", FW'(restore), FW'(lRst));
        chk("lit_count", FW'(count), FW'(lCnt));
        chk("lit_overflow", FW'(overflow), FW'(lOv));
        chk("lit_underflow", FW'(underflow), FW'(lUn));
      end
    end
  end

  task automatic drive(input logic pu, input logic po,
                       input logic [FW-1:0] f, input logic ce,
                       input logic rs);
    push = pu;
    pop = po;
    frame_in = f;
    clear_err = ce;
    reset = rs;
    litOn = 1'b0;
  endtask

  task automatic expLit(input logic [FW-1:0] o, input logic r,
                        input int c, input logic ov, input logic un);
    litOn = 1'b1;
    litOut = o;
    litRst = r;
    litCnt = c;
    litOv = ov;
    litUn = un;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [FW-1:0] fa;
  logic [FW-1:0] fb;
  logic [FW-1:0] fc;

  initial begin
    fa = mk(16'h0001);
    fb = mk(16'h0002);
    fc = mk(16'h0003);
    litOn = 1'b0;
    litOut = '0;
    litRst = 1'b0;
    litCnt = 0;
    litOv = 1'b0;
    litUn = 1'b0;
    drive(0, 0, '0, 0, 1); expLit('0, 0, 0, 0, 0); tick();

    // 1: basic push/pop
    drive(1, 0, fa, 0, 0); expLit('0, 0, 1, 0, 0); tick();
    drive(1, 0, fb, 0, 0); expLit('0, 0, 2, 0, 0); tick();
    drive(0, 1, '0, 0, 0); expLit(fb, 1, 1, 0, 0); tick();
    drive(0, 0, '0, 0, 0); expLit(fb, 0, 1, 0, 0); tick();
    drive(0, 1, '0, 0, 0); expLit(fa, 1, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0); expLit(fa, 0, 0, 0, 0); tick();

    // 2: fill, overflow, drain
    drive(0, 0, '0, 0, 1); expLit('0, 0, 0, 0, 0); tick();
    for (int i = 0; i < DP; i++) begin
      drive(1, 0, mk(16'h0100 + 16'(i)), 0, 0);
      expLit('0, 0, i + 1, 0, 0);
      tick();
    end
    drive(1, 0, mk(16'hDEAD), 0, 0); expLit('0, 0, 16, 1, 0); tick();
    for (int i = 0; i < DP; i++) begin
      drive(0, 1, '0, 0, 0);
      expLit(mk(16'h010F - 16'(i)), 1, 15 - i, 1, 0);
      tick();
    end
    drive(0, 0, '0, 0, 0); expLit(mk(16'h0100), 0, 0, 1, 0); tick();

    // 3: underflow and clear_err
    drive(0, 1, '0, 0, 0); expLit(mk(16'h0100), 0, 0, 1, 1); tick();
    drive(0, 0, '0, 1, 0); expLit(mk(16'h0100), 0, 0, 0, 0); tick();
    drive(0, 1, '0, 1, 0); expLit(mk(16'h0100), 0, 0, 0, 1); tick();
    drive(0, 0, '0, 1, 0); expLit(mk(16'h0100), 0, 0, 0, 0); tick();

    // 4: tail call
    drive(0, 0, '0, 0, 1); expLit('0, 0, 0, 0, 0); tick();
    drive(1, 0, fa, 0, 0); expLit('0, 0, 1, 0, 0); tick();
    drive(1, 0, fb, 0, 0); expLit('0, 0, 2, 0, 0); tick();
    drive(1, 1, fc, 0, 0); expLit(fb, 1, 2, 0, 0); tick();
    drive(0, 1, '0, 0, 0); expLit(fc, 1, 1, 0, 0); tick();
    drive(0, 0, '0, 0, 0); expLit(fc, 0, 1, 0, 0); tick();

    // 5: back-to-back pops, reset cancels restore
    drive(0, 0, '0, 0, 1); expLit('0, 0, 0, 0, 0); tick();
    drive(1, 0, fa, 0, 0); expLit('0, 0, 1, 0, 0); tick();
    drive(1, 0, fb, 0, 0); expLit('0, 0, 2, 0, 0); tick();
    drive(0, 1, '0, 0, 0); expLit(fb, 1, 1, 0, 0); tick();
    drive(0, 1, '0, 0, 0); expLit(fa, 1, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0); expLit(fa, 0, 0, 0, 0); tick();
    drive(1, 0, fc, 0, 0); expLit(fa, 0, 1, 0, 0); tick();
    drive(0, 1, '0, 0, 0); expLit(fc, 1, 0, 0, 0); tick();
    drive(1, 1, fa, 0, 1); expLit('0, 0, 0, 0, 0); tick();

    // 6: random traffic against the model
    drive(0, 0, '0, 0, 0); tick();
    for (int n = 0; n < 1000; n++) begin
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            randFrame(), $urandom_range(0, 19) == 0,
            $urandom_range(0, 199) == 0);
      tick();
    end
    drive(0, 0, '0, 0, 0); tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nBad);
    $finish;
  end

endmodule
